// File: rtl/biplex_pkg.sv
// Shared definitions for the biplex FFT output reorder stage: default sizes,
// the input-event classification and a bit-reversal helper.
package biplex_pkg;

   localparam int FFT_BITS  = 5;
   localparam int DATA_W    = 36;
   localparam int BITREV_W  = 16;

   // What the current en_in/sync_in cycle means for the capture side.
   typedef enum logic [1:0] {
      EV_IDLE,
      EV_FIRST,
      EV_RESYNC,
      EV_NORMAL
   } in_ev_e;

   // Reverses the low n bits of v (n <= BITREV_W): full reversal, then drop
   // the unused low-order positions.
   function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] v,
                                                   input int unsigned         n);
      logic [BITREV_W-1:0] r;
      for (int i = 0; i < BITREV_W; i++) begin
         r[i] = v[BITREV_W-1-i];
      end
      return r >> (BITREV_W - n);
   endfunction

endpackage

// File: rtl/biplex_dpram.sv
// Simple dual-port RAM for the reorder ping-pong buffer: synchronous write,
// registered read. Address is {bank, index}.
module biplex_dpram #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 36
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[raddr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/biplex_reorder.sv
// Biplex FFT output reorder: ping-pong frame buffer, written in natural order and
// read bit-reversed. Define BIPLEX_BITREV_EN for bit-reversed reads; otherwise a one-frame delay.
module biplex_reorder
   import biplex_pkg::*;
#(
   parameter int FFT_BITS = biplex_pkg::FFT_BITS,
   parameter int DATA_W   = biplex_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_in,
   input  logic              sync_in,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              valid_out,
   output logic              sync_out,
   output logic              err_resync
);

   localparam logic [FFT_BITS-1:0] CNT_LAST = '1;

   logic [FFT_BITS-1:0] cnt_q, cnt_d;
   logic                wbank_q, wbank_d;
   logic                primed_q, primed_d;
   logic                framed_q, framed_d;
   logic                err_q, err_d;
   logic                valid_q, valid_d;
   logic                sync_q, sync_d;

   in_ev_e              ev;
   logic [FFT_BITS-1:0] rd_idx;
   logic                we, re;
   logic [FFT_BITS:0]   waddr, raddr;

`ifdef BIPLEX_BITREV_EN
   assign rd_idx = FFT_BITS'(bitrev(BITREV_W'(cnt_q), FFT_BITS));
`else
   assign rd_idx = cnt_q;
`endif

   always_comb begin
      ev = EV_IDLE;
      if (en_in) begin
         if (!framed_q) begin
            ev = sync_in ? EV_FIRST : EV_IDLE;
         end else if (sync_in && (cnt_q != '0)) begin
            ev = EV_RESYNC;
         end else begin
            ev = EV_NORMAL;
         end
      end
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      cnt_d    = cnt_q;
      wbank_d  = wbank_q;
      primed_d = primed_q;
      framed_d = framed_q;
      err_d    = err_q;
      we       = 1'b0;
      re       = 1'b0;
      waddr    = {wbank_q, cnt_q};
      raddr    = {~wbank_q, rd_idx};

      unique case (ev)
         EV_FIRST: begin
            framed_d = 1'b1;
            we       = 1'b1;
            cnt_d    = FFT_BITS'(1);
         end
         EV_RESYNC: begin
            // Restart the capture in a fresh bank; its previous contents are a torn frame.
            wbank_d  = ~wbank_q;
            waddr    = {~wbank_q, {FFT_BITS{1'b0}}};
            we       = 1'b1;
            cnt_d    = FFT_BITS'(1);
            primed_d = 1'b0;
            err_d    = 1'b1;
         end
         EV_NORMAL: begin
            we    = 1'b1;
            re    = primed_q;
            cnt_d = cnt_q + FFT_BITS'(1);
            if (cnt_q == CNT_LAST) begin
               wbank_d  = ~wbank_q;
               primed_d = 1'b1;
            end
         end
         default: ;
      endcase

      valid_d = re;
      sync_d  = re && (cnt_q == '0);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         wbank_q  <= 1'b0;
         primed_q <= 1'b0;
         framed_q <= 1'b0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         sync_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         wbank_q  <= wbank_d;
         primed_q <= primed_d;
         framed_q <= framed_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         sync_q   <= sync_d;
      end
   end

   biplex_dpram #(
      .ADDR_W (FFT_BITS + 1),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (waddr),
      .wdata (din),
      .re    (re),
      .raddr (raddr),
      .rdata (dout)
   );

   assign valid_out  = valid_q;
   assign sync_out   = sync_q;
   assign err_resync = err_q;

endmodule

// File: tb/tb_biplex_reorder.sv
// Directed bench for biplex_reorder with FFT_BITS=3; expected output order
// follows BIPLEX_BITREV_EN the same way the design does.
module tb_biplex_reorder;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_in;
   logic        sync_in;
   logic [35:0] din;
   logic [35:0] dout;
   logic        valid_out;
   logic        sync_out;
   logic        err_resync;

   int checks = 0;
   int errors = 0;

   biplex_reorder #(
      .FFT_BITS (3),
      .DATA_W   (36)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en_in      (en_in),
      .sync_in    (sync_in),
      .din        (din),
      .dout       (dout),
      .valid_out  (valid_out),
      .sync_out   (sync_out),
      .err_resync (err_resync)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change just after a falling edge; outputs are sampled at the next falling edge.
   task automatic tick(input logic en, input logic s, input logic [35:0] d);
      en_in   = en;
      sync_in = s;
      din     = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Value expected at output slot i of a frame whose first input sample was base.
   function automatic logic [35:0] ord(input int base, input int i);
`ifdef BIPLEX_BITREV_EN
      logic [2:0] v;
      logic [2:0] r;
      v = 3'(i);
      for (int b = 0; b < 3; b++) r[b] = v[2-b];
      return 36'(base) + 36'(r);
`else
      return 36'(base + i);
`endif
   endfunction

   initial begin
      rst     = 1'b0;
      en_in   = 1'b0;
      sync_in = 1'b0;
      din     = '0;
      @(negedge clk);
      check("rst_dout", dout, 36'h0);
      check("rst_valid", valid_out, 1'b0);
      check("rst_sync", sync_out, 1'b0);
      check("rst_err", err_resync, 1'b0);
      rst = 1'b1;

      // Samples before any sync are discarded.
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 36'hAA + 36'(i));
         check($sformatf("junk_valid%0d", i), valid_out, 1'b0);
      end

      // Frame A: capture only.
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, i == 0, 36'(i));
         check($sformatf("a_valid%0d", i), valid_out, 1'b0);
      end

      // Frame B in, frame A out.
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, i == 0, 36'(8 + i));
         check($sformatf("a_dout%0d", i), dout, ord(0, i));
         check($sformatf("a_vld%0d", i), valid_out, 1'b1);
         check($sformatf("a_sync%0d", i), sync_out, i == 0);
      end

      // Frame C in with en_in low every other cycle, frame B out.
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, i == 0, 36'(16 + i));
         check($sformatf("b_dout%0d", i), dout, ord(8, i));
         check($sformatf("b_vld%0d", i), valid_out, 1'b1);
         check($sformatf("b_sync%0d", i), sync_out, i == 0);
         tick(1'b0, 1'b0, 36'h0);
         check($sformatf("b_gapvld%0d", i), valid_out, 1'b0);
         check($sformatf("b_gapsync%0d", i), sync_out, 1'b0);
      end

      // Frame D in, frame C out.
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, i == 0, 36'(24 + i));
         check($sformatf("c_dout%0d", i), dout, ord(16, i));
         check($sformatf("c_vld%0d", i), valid_out, 1'b1);
      end

      // Partial frame E, then a sync at cnt=5.
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, i == 0, 36'(32 + i));
         check($sformatf("d_dout%0d", i), dout, ord(24, i));
      end
      check("err_before", err_resync, 1'b0);
      tick(1'b1, 1'b1, 36'd100);
      check("err_set", err_resync, 1'b1);
      check("resync_vld", valid_out, 1'b0);
      for (int i = 1; i < 8; i++) begin
         tick(1'b1, 1'b0, 36'(100 + i));
         check($sformatf("refill_vld%0d", i), valid_out, 1'b0);
         check($sformatf("err_sticky%0d", i), err_resync, 1'b1);
      end

      // Frame F in, realigned frame out; reset arrives mid-output.
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, i == 0, 36'(200 + i));
         check($sformatf("r_dout%0d", i), dout, ord(100, i));
         check($sformatf("r_vld%0d", i), valid_out, 1'b1);
         check($sformatf("r_sync%0d", i), sync_out, i == 0);
      end
      #2;
      rst   = 1'b0;
      en_in = 1'b0;
      #1;
      check("arst_dout", dout, 36'h0);
      check("arst_valid", valid_out, 1'b0);
      check("arst_sync", sync_out, 1'b0);
      check("arst_err", err_resync, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // After reset the stream must re-sync before anything comes out.
      tick(1'b1, 1'b0, 36'hAA);
      check("post_junk_vld", valid_out, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, i == 0, 36'(300 + i));
         check($sformatf("g_vld%0d", i), valid_out, 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, i == 0, 36'(400 + i));
         check($sformatf("g_dout%0d", i), dout, ord(300, i));
         check($sformatf("g_valid%0d", i), valid_out, 1'b1);
         check($sformatf("g_sync%0d", i), sync_out, i == 0);
      end
      tick(1'b0, 1'b0, 36'h0);
      check("idle_vld", valid_out, 1'b0);
      check("idle_err", err_resync, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
